// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl
//   Machine-cycle (T-state) sequencer for the 8085 external bus. A one-shot
//   cycle request from decode is expanded into the T1/T2/Twait/T3/(T4) pin
//   pattern. READY inserts wait states, and a watchdog bounds them. HOLD is
//   arbitrated at cycle boundaries.
//
// Handshake: req is a one-shot strobe, not valid/ready. It is sampled only in
//   TIDLE or in the last T-state of a cycle. If it is not sampled there, it is
//   simply not seen. A legal req that is sampled latches cyc_type/addr/wdata
//   and starts T1 on the next edge. Completion is reported by a one-cycle
//   pulse on done.
//
// Ports
//   phi1, rst             clock (rising edge), synchronous active-high reset
//   req, cyc_type         cycle request and type (0 OF, 1 MR, 2 MW, 3 IOR, 4 IOW)
//   addr, wdata           cycle address / write data, latched with req
//   ready, hold           external READY and HOLD
//   ad_in/ad_out/ad_oe    multiplexed AD bus
//   haddress, bus_oe      A15..A8 and the enable for address/strobe pins
//   ALE, RDn, WRn, IOMn   bus strobes
//   S1, S0                cycle status
//   rd_data               captured read data
//   done, busy, hlda      completion pulse, cycle in progress, hold ack
//   wait_timeout          watchdog fired in the current/last cycle
//   state_dbg             current T-state encoding, for observation
module bus_cycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        phi1,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  cyc_type,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        ready,
    input  logic        hold,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic [7:0]  haddress,
    output logic        bus_oe,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        IOMn,
    output logic        S1,
    output logic        S0,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic        busy,
    output logic        hlda,
    output logic        wait_timeout,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        TIDLE = 3'd0, T1 = 3'd1, T2 = 3'd2, TWAIT = 3'd3,
        T3 = 3'd4, T4 = 3'd5, THOLD = 3'd6
    } state_t;

    state_t              state, state_n;
    logic [7:0]          wdata_q;
    logic [2:0]          type_q;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
    logic                req_ok, load, timeout_hit, cycle_end;

    logic [7:0]  ad_out_d, haddress_d, rd_data_d;
    logic        ad_oe_d, bus_oe_d, ale_d, rdn_d, wrn_d, iomn_d, s1_d, s0_d;
    logic        done_d, busy_d, hlda_d, wait_timeout_d;

    // Opcode fetch, memory read and IO read drive RDn. The other types drive WRn.
    function automatic logic is_read(input logic [2:0] t);
        return (t == 3'd0) || (t == 3'd1) || (t == 3'd3);
    endfunction

    assign req_ok    = req && (cyc_type <= 3'd4);
    assign state_dbg = state;

    // State register
    always_ff @(posedge phi1) begin
        if (rst) begin
            state <= TIDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n     = state;
        load        = 1'b0;
        timeout_hit = 1'b0;
        cycle_end   = 1'b0;
        case (state)
            TIDLE: begin
                if (hold) begin
                    state_n = THOLD;
                end else if (req_ok) begin
                    state_n = T1;
                    load    = 1'b1;
                end
            end
            T1:    state_n = T2;
            T2:    state_n = ready ? T3 : TWAIT;
            TWAIT: begin
                // The watchdog wins over READY, so a stuck slave cannot hang the bus.
                if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    state_n     = T3;
                    timeout_hit = 1'b1;
                end else if (ready) begin
                    state_n = T3;
                end
            end
            T3: begin
                if (type_q == 3'd0) state_n = T4;
                else                cycle_end = 1'b1;
            end
            T4:    cycle_end = 1'b1;
            THOLD: if (!hold) state_n = TIDLE;
            default: state_n = TIDLE;
        endcase
        // At a cycle boundary, hold beats a back-to-back request.
        if (cycle_end) begin
            if (hold) begin
                state_n = THOLD;
            end else if (req_ok) begin
                state_n = T1;
                load    = 1'b1;
            end else begin
                state_n = TIDLE;
            end
        end
    end

    // Output logic: next values of the registered pins, decoded from the state
    // being entered. Each pin therefore settles in the same cycle as its state.
    always_comb begin
        ale_d          = 1'b0;
        rdn_d          = 1'b1;
        wrn_d          = 1'b1;
        ad_oe_d        = 1'b0;
        bus_oe_d       = 1'b1;
        busy_d         = 1'b0;
        hlda_d         = 1'b0;
        ad_out_d       = ad_out;
        haddress_d     = haddress;
        iomn_d         = IOMn;
        s1_d           = S1;
        s0_d           = S0;
        rd_data_d      = rd_data;
        done_d         = cycle_end;
        wait_timeout_d = wait_timeout | timeout_hit;
        wait_cnt_d     = wait_cnt;

        if (state == T3 && is_read(type_q)) rd_data_d = ad_in;

        case (state_n)
            T1: begin
                // T1 is entered only on a load, so the live inputs are the new cycle.
                ale_d          = 1'b1;
                ad_oe_d        = 1'b1;
                busy_d         = 1'b1;
                ad_out_d       = addr[7:0];
                haddress_d     = addr[15:8];
                wait_cnt_d     = '0;
                wait_timeout_d = 1'b0;
                case (cyc_type)
                    3'd0:    {s1_d, s0_d, iomn_d} = 3'b110;
                    3'd1:    {s1_d, s0_d, iomn_d} = 3'b100;
                    3'd2:    {s1_d, s0_d, iomn_d} = 3'b010;
                    3'd3:    {s1_d, s0_d, iomn_d} = 3'b101;
                    3'd4:    {s1_d, s0_d, iomn_d} = 3'b011;
                    default: {s1_d, s0_d, iomn_d} = {S1, S0, IOMn};
                endcase
            end
            T2, TWAIT, T3: begin
                busy_d = 1'b1;
                if (is_read(type_q)) begin
                    rdn_d = 1'b0;
                end else begin
                    wrn_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_q;
                end
                if (state_n == TWAIT) wait_cnt_d = wait_cnt + WAIT_W'(1);
            end
            T4: busy_d = 1'b1;
            THOLD: begin
                bus_oe_d = 1'b0;
                hlda_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Output and cycle-latch registers
    always_ff @(posedge phi1) begin
        if (rst) begin
            wdata_q      <= '0;
            type_q       <= '0;
            wait_cnt     <= '0;
            ad_out       <= '0;
            ad_oe        <= 1'b0;
            haddress     <= '0;
            bus_oe       <= 1'b1;
            ALE          <= 1'b0;
            RDn          <= 1'b1;
            WRn          <= 1'b1;
            IOMn         <= 1'b0;
            S1           <= 1'b0;
            S0           <= 1'b0;
            rd_data      <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            hlda         <= 1'b0;
            wait_timeout <= 1'b0;
        end else begin
            if (load) begin
                wdata_q <= wdata;
                type_q  <= cyc_type;
            end
            wait_cnt     <= wait_cnt_d;
            ad_out       <= ad_out_d;
            ad_oe        <= ad_oe_d;
            haddress     <= haddress_d;
            bus_oe       <= bus_oe_d;
            ALE          <= ale_d;
            RDn          <= rdn_d;
            WRn          <= wrn_d;
            IOMn         <= iomn_d;
            S1           <= s1_d;
            S0           <= s0_d;
            rd_data      <= rd_data_d;
            done         <= done_d;
            busy         <= busy_d;
            hlda         <= hlda_d;
            wait_timeout <= wait_timeout_d;
        end
    end

endmodule
